// File: rtl/regfile_writeback_pkg.sv
// Shared core package for the writeback slice: data width, register count,
// register-index type and the register-zero helper.
package regfile_writeback_pkg;

    localparam int XLEN     = 64;
    localparam int NREG     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Register x0 is hardwired; nothing is ever written to or tracked for it.
    function automatic logic is_real_reg(input reg_idx_t idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations with a two-port
// RAW-hazard query.
// Optional feature: WB_EARLY_RELEASE_EN lets a register being released this
// cycle stop stalling in the same cycle; otherwise only registered busy bits
// are consulted.
module wb_scoreboard #(
    parameter int NREG = regfile_writeback_pkg::NREG
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       stall
);
    import regfile_writeback_pkg::*;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] busy_view;
    logic            hit1;
    logic            hit2;

    // Next busy vector: clear first so a same-index set in the same cycle wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en && is_real_reg(set_idx)) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy register; reset drops every outstanding long-latency destination.
    // NOTE: every busy bit is reset, since a stale bit would stall decode forever.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Busy view used by the hazard query, optionally excluding the index being released.
    always_comb begin
        busy_view = busy;
`ifdef WB_EARLY_RELEASE_EN
        if (clr_en) begin
            busy_view[clr_idx] = 1'b0;
        end
`endif
    end

    assign hit1  = is_real_reg(rs1) && busy_view[rs1];
    assign hit2  = is_real_reg(rs2) && busy_view[rs2];
    assign stall = hit1 || hit2;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: merges a single-cycle ALU result and a long-latency
// (load/mul/div) result into one registered register-file write port, and
// tracks pending long-latency destinations for decode-stage RAW stalls.
// Optional feature: WB_EARLY_RELEASE_EN (passed through to wb_scoreboard).
module regfile_writeback #(
    parameter int XLEN = regfile_writeback_pkg::XLEN,
    parameter int NREG = regfile_writeback_pkg::NREG
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_long,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_wdata,
    output logic            reg_wen
);
    import regfile_writeback_pkg::*;

    logic            lsu_accept;
    logic            wb_take;
    reg_idx_t        wb_idx;
    logic [XLEN-1:0] wb_data;
    logic            long_issue;

    // The ALU has no backpressure, so it always wins; lsu waits whenever the ALU is busy.
    assign lsu_ready  = !alu_valid;
    assign lsu_accept = lsu_valid && lsu_ready;
    assign long_issue = issue_valid && issue_long;

    // Select the accepted result for this cycle; destination 0 is consumed without a write.
    always_comb begin
        wb_take = 1'b0;
        wb_idx  = REG_ZERO;
        wb_data = '0;
        if (alu_valid) begin
            wb_take = is_real_reg(alu_rd);
            wb_idx  = alu_rd;
            wb_data = alu_data;
        end else if (lsu_accept) begin
            wb_take = is_real_reg(lsu_rd);
            wb_idx  = lsu_rd;
            wb_data = lsu_data;
        end
    end

    // Registered write port: one-cycle enable pulse, index and data hold while idle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_wen  <= 1'b0;
            rd       <= '0;
            rd_wdata <= '0;
        end else begin
            reg_wen <= wb_take;
            if (wb_take) begin
                rd       <= wb_idx;
                rd_wdata <= wb_data;
            end
        end
    end

    wb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_en  (long_issue),
        .set_idx (issue_rd),
        .clr_en  (lsu_accept),
        .clr_idx (lsu_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .stall   (stall)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
// Honours WB_EARLY_RELEASE_EN for the same-cycle release expectation.
module tb_regfile_writeback;

    localparam int XLEN = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_long;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            stall;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_wdata;
    logic            reg_wen;

    int checks   = 0;
    int failures = 0;

`ifdef WB_EARLY_RELEASE_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    always #5 clock = ~clock;

    regfile_writeback dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .rs1         (rs1),
        .rs2         (rs2),
        .stall       (stall),
        .rd          (rd),
        .rd_wdata    (rd_wdata),
        .reg_wen     (reg_wen)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_long  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rs1   = '0;
        rs2   = '0;
        reset = 1'b1;
        #2;

        // Reset state and lsu_ready still following alu_valid under reset.
        check("rst_wen", reg_wen, 0);
        check("rst_rd", rd, 0);
        check("rst_wdata", rd_wdata, 0);
        check("rst_stall", stall, 0);
        check("rst_ready_idle", lsu_ready, 1);
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
        #1 check("rst_ready_alu", lsu_ready, 0);
        // Issue and lsu under reset must take no effect.
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h44;
        step();
        check("rst_no_write", reg_wen, 0);
        idle_inputs();
        reset = 1'b0;
        rs1 = 5'd3;
        #1 check("rst_no_busy", stall, 0);
        rs1 = '0;

        // Basic ALU writeback and one-cycle pulse with hold.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        step();
        idle_inputs();
        check("alu_wen", reg_wen, 1);
        check("alu_rd", rd, 5);
        check("alu_wdata", rd_wdata, 64'h1234);
        step();
        check("alu_wen_drop", reg_wen, 0);
        check("alu_rd_hold", rd, 5);
        check("alu_wdata_hold", rd_wdata, 64'h1234);

        // Long-latency RAW stall on rd=10.
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd10;
        step();
        idle_inputs();
        rs1 = 5'd10;
        #1 check("raw_stall_0", stall, 1);
        step();
        check("raw_stall_1", stall, 1);
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 64'hAA;
        #1 check("raw_ready", lsu_ready, 1);
        check("raw_release_same", stall, !EARLY);
        step();
        idle_inputs();
        check("raw_lsu_wen", reg_wen, 1);
        check("raw_lsu_rd", rd, 10);
        check("raw_lsu_wdata", rd_wdata, 64'hAA);
        check("raw_release_next", stall, 0);
        rs1 = '0;

        // ALU/lsu collision: ALU first, lsu one cycle later.
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd12;
        step();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 64'h44;
        rs1 = 5'd12;
        #1 check("coll_ready", lsu_ready, 0);
        check("coll_stall", stall, 1);
        step();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        check("coll_alu_rd", rd, 3);
        check("coll_alu_wdata", rd_wdata, 64'h33);
        #1 check("coll_ready_after", lsu_ready, 1);
        step();
        idle_inputs();
        check("coll_lsu_wen", reg_wen, 1);
        check("coll_lsu_rd", rd, 12);
        check("coll_lsu_wdata", rd_wdata, 64'h44);
        check("coll_stall_clear", stall, 0);
        rs1 = '0;

        // Destination 0: no write, no busy.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
        step();
        idle_inputs();
        check("x0_alu_wen", reg_wen, 0);
        check("x0_rd_hold", rd, 12);
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd0;
        step();
        idle_inputs();
        check("x0_no_stall", stall, 0);

        // rs2 port hazard.
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        step();
        idle_inputs();
        rs2 = 5'd9;
        #1 check("rs2_stall", stall, 1);
        rs2 = '0;

        // Non-long issue must not set busy.
        issue_valid = 1'b1; issue_long = 1'b0; issue_rd = 5'd14;
        step();
        idle_inputs();
        rs1 = 5'd14;
        #1 check("short_no_busy", stall, 0);

        // Same-edge set and clear of rd=7 leaves it busy; lsu still written.
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
        step();
        idle_inputs();
        rs1 = 5'd7;
        #1 check("setclr_busy", stall, 1);
        check("setclr_wen", reg_wen, 1);
        check("setclr_wdata", rd_wdata, 64'h77);

        // lsu result to a non-busy index is written, busy untouched.
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h55;
        step();
        idle_inputs();
        check("nobusy_rd", rd, 20);
        check("nobusy_wdata", rd_wdata, 64'h55);
        check("nobusy_keep7", stall, 1);
        rs1 = 5'd20;
        #1 check("nobusy_20", stall, 0);

        // Reset mid-stream discards pending write and busy bits at once.
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h99;
        rs1 = 5'd7; rs2 = 5'd9;
        step();
        idle_inputs();
        check("pre_rst_wen", reg_wen, 1);
        reset = 1'b1;
        #1 check("mid_rst_wen", reg_wen, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_rd", rd, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_stall", stall, 0);
        check("post_rst_wen", reg_wen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter XLEN, 64, register data width.
REQ-002 SHALL have parameter NREG, 32, number of architectural registers (index width 5).
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port alu_valid  input  1  single-cycle result present, no backpressure.
REQ-006 SHALL have port alu_rd  input  5  ALU destination index.
REQ-007 SHALL have port alu_data  input  XLEN  ALU result.
REQ-008 SHALL have port lsu_valid  input  1  long-latency (load/mul/div) result offered.
REQ-009 SHALL have port lsu_ready  output  1  long-latency result accepted this cycle when high with lsu_valid.
REQ-010 SHALL have port lsu_rd  input  5  long-latency destination index.
REQ-011 SHALL have port lsu_data  input  XLEN  long-latency result.
REQ-012 SHALL have port issue_valid  input  1  instruction issued this cycle.
REQ-013 SHALL have port issue_rd  input  5  issued instruction destination.
REQ-014 SHALL have port issue_long  input  1  issued instruction completes via lsu channel.
REQ-015 SHALL have port rs1  input  5  decode-stage source 1 index.
REQ-016 SHALL have port rs2  input  5  decode-stage source 2 index.
REQ-017 SHALL have port stall  output  1  RAW hazard on a pending long-latency destination.
REQ-018 SHALL have port rd  output  5  register-file write index.
REQ-019 SHALL have port rd_wdata  output  XLEN  register-file write data.
REQ-020 SHALL have port reg_wen  output  1  register-file write enable.

Function
REQ-021 rd/rd_wdata/reg_wen SHALL be registered: a result accepted in cycle N drives the register-file write port in cycle N+1, high for exactly one cycle.
REQ-022 Priority: ALU over lsu; lsu_ready SHALL equal !alu_valid (combinational, independent of lsu_valid).
REQ-023 A result with destination 0 SHALL be consumed but SHALL produce reg_wen=0.
REQ-024 Idle cycle (no accepted result): reg_wen=0, rd and rd_wdata hold last value.
REQ-025 Scoreboard: NREG busy bits; issue_valid && issue_long && issue_rd!=0 SHALL set busy[issue_rd] at the edge.
REQ-026 Accepted lsu result SHALL clear busy[lsu_rd] at the edge; simultaneous set and clear of the same index SHALL leave it set.
REQ-027 stall SHALL be (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]); busy[0] SHALL never be set.
REQ-028 lsu result to a non-busy index SHALL still be written (no drop), busy unchanged.

Reset
REQ-029 While reset high: reg_wen=0, rd=0, rd_wdata=0, all busy bits 0, stall=0; lsu_ready SHALL still follow REQ-022 but no acceptance takes effect.
REQ-030 Reset asserted mid-operation SHALL discard any pending write and all outstanding busy bits at once.

Configuration
REQ-031 Macro WB_EARLY_RELEASE_EN: when defined, stall SHALL exclude an index being cleared this cycle (lsu_valid && lsu_ready && lsu_rd==that index); when undefined, stall SHALL use registered busy bits only.

Structure
REQ-032 XLEN, NREG, register-index typedef SHALL live in the shared core package.
REQ-033 Scoreboard SHALL be a sub-module named wb_scoreboard (busy array, set/clear, two-port stall query).

Verification
REQ-034 alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle N -> cycle N+1 reg_wen=1, rd=5, rd_wdata=0x1234; N+2 reg_wen=0.
REQ-035 issue long rd=10, then rs1=10 -> stall=1 each cycle until lsu_valid rd=10 accepted; stall=0 next cycle (same cycle with WB_EARLY_RELEASE_EN).
REQ-036 alu_valid=1 and lsu_valid=1 same cycle -> lsu_ready=0, ALU written; lsu result written one cycle later once alu_valid=0.
REQ-037 alu_rd=0, alu_data=0xFFFF -> reg_wen stays 0; issue long rd=0 -> stall never asserts for rs1=0.
REQ-038 Issue long rd=7 and accept lsu rd=7 same edge -> busy[7]=1 afterwards; reset pulse mid-stream -> reg_wen=0, stall=0 immediately.
